// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot/one-cold decoder.
// Direct mode decodes addr_in on a handshake; sweep mode walks every line with a programmable dwell.
module decoder_nx2n_seq #(
   parameter int N          = 3,
   parameter int HOLD_W     = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic [N-1:0]        addr_in,
   input  logic                valid_in,
   input  logic                start,
   input  logic [HOLD_W-1:0]   dwell,
   output logic                ready_out,
   output logic [(1<<N)-1:0]   d_out,
   output logic [N-1:0]        addr_out,
   output logic                busy,
   output logic                done
);

   localparam int W = 1 << N;
   localparam logic [W-1:0] INACTIVE  = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
   localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

   // Handshake: valid_in (direct) or start (sweep) is accepted on a rising edge
   // only while ready_out=1; mode picks which one is honoured, the other is dropped.
   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [W-1:0]        d_q, d_d;
   logic [N-1:0]        addr_q, addr_d;
   logic [HOLD_W-1:0]   cnt_q, cnt_d;
   logic [HOLD_W-1:0]   dwell_q, dwell_d;
   logic                done_q, done_d;

   function automatic logic [W-1:0] decode(input logic [N-1:0] a);
      logic [W-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return (ACTIVE_LOW != 0) ? ~v : v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         d_q     <= INACTIVE;
         addr_q  <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!en) begin
               d_d = INACTIVE;
            end else if (mode && start) begin
               state_d = SWEEP;
               dwell_d = dwell;
               cnt_d   = '0;
               addr_d  = '0;
               d_d     = decode('0);
            end else if (!mode && valid_in) begin
               addr_d = addr_in;
               d_d    = decode(addr_in);
            end
         end
         SWEEP: begin
            // Abort blanks immediately; address is left where it stopped.
            if (!en) begin
               state_d = IDLE;
               d_d     = INACTIVE;
               cnt_d   = '0;
            end else if (cnt_q == dwell_q) begin
               cnt_d = '0;
               if (addr_q == LAST_ADDR) begin
                  state_d = IDLE;
                  d_d     = INACTIVE;
                  done_d  = 1'b1;
               end else begin
                  addr_d = addr_q + N'(1);
                  d_d    = decode(addr_q + N'(1));
               end
            end else begin
               cnt_d = cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            d_d     = INACTIVE;
         end
      endcase
   end

   assign ready_out = (state_q == IDLE);
   assign busy      = (state_q == SWEEP);
   assign d_out     = d_q;
   assign addr_out  = addr_q;
   assign done      = done_q;

endmodule
